tile_ccff_ctrl: RTL and testbench

Parametrised configuration-chain controller for a tile, the next generation of the plain ccff_head→ccff_tail chains in our tiles. It shifts NUM_CHAINS parallel chains of CHAIN_LEN bits each, then commits the shifted frame into a shadow register that drives the routing muxes. The shadow register means the tile keeps its old configuration glitch-free while a new frame is shifted. It adds frame-length checking, shadow readback and config-qualified pad isolation.

---
 rtl/tile_cfg_pkg.sv | 14 +
 rtl/ccff_chain_slice.sv | 36 +++
 rtl/tile_ccff_ctrl.sv | 131 +++++++++++++
 tb/tb_tile_ccff_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tile_cfg_pkg.sv
// Shared constants for the tile configuration-chain controller: FSM encodings
// and the bit-counter width helper.
package tile_cfg_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT    = 2'd1;
    localparam logic [1:0] ST_READBACK = 2'd2;

    // The counter must hold 0..len+1, where len+1 marks an over-long frame.
    function automatic int cnt_w(input int len);
        return $clog2(len + 2);
    endfunction

endpackage

// File: rtl/ccff_chain_slice.sv
// One configuration chain: a serial shift register plus the shadow copy that
// drives the routing muxes, with load (shadow->shift) and commit (shift->shadow).
module ccff_chain_slice #(
    parameter int CHAIN_LEN = 64
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 head,
    input  logic                 shift,
    input  logic                 load,
    input  logic                 commit,
    output logic                 tail,
    output logic [CHAIN_LEN-1:0] shadow
);

    logic [CHAIN_LEN-1:0] shift_reg;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shift_reg <= '0;
            shadow    <= '0;
        end else begin
            if (load) begin
                shift_reg <= shadow;
            end else if (shift) begin
                shift_reg <= {shift_reg[CHAIN_LEN-2:0], head};
            end
            if (commit) begin
                shadow <= shift_reg;
            end
        end
    end

    assign tail = shift_reg[CHAIN_LEN-1];

endmodule

// File: rtl/tile_ccff_ctrl.sv
// Tile configuration controller: NUM_CHAINS parallel chains shifted together,
// committed into a shadow register, with frame-length checking and readback.
module tile_ccff_ctrl
    import tile_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 64,
    parameter int CNT_W      = cnt_w(CHAIN_LEN)
) (
    input  logic                            prog_clk,
    input  logic                            prog_reset,
    input  logic [NUM_CHAINS-1:0]           ccff_head,
    input  logic                            shift_en,
    input  logic                            commit_req,
    input  logic                            readback_req,
    input  logic                            isol_n,
    output logic [NUM_CHAINS-1:0]           ccff_tail,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_bits,
    output logic                            cfg_valid,
    output logic                            isol_n_out,
    output logic                            busy,
    output logic                            frame_err,
    output logic [CNT_W-1:0]                bit_count,
    output logic [1:0]                      fsm_state
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(CHAIN_LEN + 1);

    // Control inputs are level-sampled each prog_clk edge with no back-pressure:
    // commit_req and readback_req are single-cycle pulses, shift_en is a
    // per-cycle enable; priority is commit_req > readback_req > shift_en.
    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             err_nx, valid_nx;
    logic             do_shift, do_load, do_commit;

    always_comb begin
        state_nx  = state;
        cnt_nx    = bit_count;
        err_nx    = frame_err;
        valid_nx  = cfg_valid;
        do_shift  = 1'b0;
        do_load   = 1'b0;
        do_commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) begin
                    err_nx = 1'b1;
                end else if (readback_req) begin
                    do_load  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ST_READBACK;
                end else if (shift_en) begin
                    do_shift = 1'b1;
                    cnt_nx   = CNT_W'(1);
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (commit_req) begin
                    if (bit_count == LEN_C) begin
                        do_commit = 1'b1;
                        valid_nx  = 1'b1;
                        err_nx    = 1'b0;
                    end else begin
                        err_nx = 1'b1;
                    end
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else if (shift_en) begin
                    // Shifting continues past a full frame so bits still pass
                    // through to the next tile; the count parks at the marker.
                    do_shift = 1'b1;
                    if (bit_count != MAX_C) begin
                        cnt_nx = bit_count + 1'b1;
                    end
                end
            end
            ST_READBACK: begin
                if (shift_en) begin
                    do_shift = 1'b1;
                    if (bit_count == LEN_C - 1'b1) begin
                        cnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_nx = bit_count + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state     <= ST_IDLE;
            bit_count <= '0;
            frame_err <= 1'b0;
            cfg_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_count <= cnt_nx;
            frame_err <= err_nx;
            cfg_valid <= valid_nx;
        end
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        ccff_chain_slice #(
            .CHAIN_LEN(CHAIN_LEN)
        ) u_slice (
            .prog_clk  (prog_clk),
            .prog_reset(prog_reset),
            .head      (ccff_head[c]),
            .shift     (do_shift),
            .load      (do_load),
            .commit    (do_commit),
            .tail      (ccff_tail[c]),
            .shadow    (cfg_bits[c*CHAIN_LEN +: CHAIN_LEN])
        );
    end

    assign isol_n_out = isol_n & cfg_valid;
    assign busy       = (state != ST_IDLE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_tile_ccff_ctrl.sv
// Directed bench for tile_ccff_ctrl with CHAIN_LEN=8, NUM_CHAINS=2; serial
// output bits are predicted into a queue and popped as the chain emits them.
module tb_tile_ccff_ctrl;

    localparam int NC = 2;
    localparam int CL = 8;
    localparam int CW = $clog2(CL + 2);

    logic              prog_clk;
    logic              prog_reset;
    logic [NC-1:0]     ccff_head;
    logic              shift_en;
    logic              commit_req;
    logic              readback_req;
    logic              isol_n;
    logic [NC-1:0]     ccff_tail;
    logic [NC*CL-1:0]  cfg_bits;
    logic              cfg_valid;
    logic              isol_n_out;
    logic              busy;
    logic              frame_err;
    logic [CW-1:0]     bit_count;
    logic [1:0]        fsm_state;

    logic [1:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    tile_ccff_ctrl #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .ccff_head   (ccff_head),
        .shift_en    (shift_en),
        .commit_req  (commit_req),
        .readback_req(readback_req),
        .isol_n      (isol_n),
        .ccff_tail   (ccff_tail),
        .cfg_bits    (cfg_bits),
        .cfg_valid   (cfg_valid),
        .isol_n_out  (isol_n_out),
        .busy        (busy),
        .frame_err   (frame_err),
        .bit_count   (bit_count),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // driver tasks
    task automatic shift_pair(input logic b0, input logic b1);
        ccff_head = {b1, b0};
        shift_en  = 1'b1;
        tick();
        shift_en  = 1'b0;
        ccff_head = '0;
    endtask

    task automatic shift_bytes(input logic [7:0] v0, input logic [7:0] v1, input int n);
        for (int i = 0; i < n; i++) shift_pair(v0[7-i], v1[7-i]);
    endtask

    task automatic commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    initial begin
        logic [1:0] b;
        prog_reset   = 1'b1;
        ccff_head    = '0;
        shift_en     = 1'b0;
        commit_req   = 1'b0;
        readback_req = 1'b0;
        isol_n       = 1'b1;
        tick();
        tick();
        prog_reset = 1'b0;

        chk("rst_cfg_bits", cfg_bits, 16'h0000);
        chk("rst_valid", 16'(cfg_valid), 16'h0);
        chk("rst_isol", 16'(isol_n_out), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_count", 16'(bit_count), 16'h0);
        chk("rst_tail", 16'(ccff_tail), 16'h0);

        // Commit in IDLE is a zero-length frame.
        commit();
        chk("idle_commit_err", 16'(frame_err), 16'h1);
        chk("idle_commit_cfg", cfg_bits, 16'h0000);

        // Full frame then commit.
        shift_bytes(8'hA5, 8'h3C, 8);
        chk("full_count", 16'(bit_count), 16'd8);
        chk("full_busy", 16'(busy), 16'h1);
        chk("full_state", 16'(fsm_state), 16'h1);
        commit();
        chk("commit_cfg", cfg_bits, 16'h3CA5);
        chk("commit_valid", 16'(cfg_valid), 16'h1);
        chk("commit_isol", 16'(isol_n_out), 16'h1);
        chk("commit_err", 16'(frame_err), 16'h0);
        chk("commit_busy", 16'(busy), 16'h0);
        isol_n = 1'b0;
        #1;
        chk("isol_follow", 16'(isol_n_out), 16'h0);
        isol_n = 1'b1;

        // Short frame.
        shift_bytes(8'hFF, 8'h00, 7);
        chk("short_count", 16'(bit_count), 16'd7);
        commit();
        chk("short_err", 16'(frame_err), 16'h1);
        chk("short_cfg", cfg_bits, 16'h3CA5);
        chk("short_count0", 16'(bit_count), 16'h0);

        shift_bytes(8'hFF, 8'h00, 8);
        commit();
        chk("ff_cfg", cfg_bits, 16'h00FF);
        chk("ff_err", 16'(frame_err), 16'h0);

        // Overflow: tail must show the bits entered 8 shifts earlier.
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            b = 2'($urandom_range(0, 3));
            exp_q.push_back(b);
            shift_pair(b[0], b[1]);
            if (i >= CL - 1) chk("ovf_tail", 16'(ccff_tail), 16'(exp_q.pop_front()));
        end
        exp_q.delete();
        chk("ovf_count", 16'(bit_count), 16'd9);
        commit();
        chk("ovf_err", 16'(frame_err), 16'h1);
        chk("ovf_cfg", cfg_bits, 16'h00FF);

        // Shift and commit together at a full count: the shift is dropped.
        shift_bytes(8'hA5, 8'h3C, 8);
        ccff_head  = 2'b11;
        shift_en   = 1'b1;
        commit_req = 1'b1;
        tick();
        shift_en   = 1'b0;
        commit_req = 1'b0;
        ccff_head  = '0;
        chk("both_cfg", cfg_bits, 16'h3CA5);
        chk("both_count", 16'(bit_count), 16'h0);
        chk("both_tail", 16'(ccff_tail), 16'b01);

        // Readback of the shadow, MSB first on both chains.
        readback_req = 1'b1;
        tick();
        readback_req = 1'b0;
        chk("rb_busy", 16'(busy), 16'h1);
        chk("rb_state", 16'(fsm_state), 16'h2);
        for (int i = 0; i < CL; i++) begin
            logic [7:0] s0, s1;
            s0 = 8'hA5;
            s1 = 8'h3C;
            exp_q.push_back({s1[7-i], s0[7-i]});
        end
        for (int i = 0; i < CL; i++) begin
            chk("rb_tail", 16'(ccff_tail), 16'(exp_q.pop_front()));
            if (i == 3) commit_req = 1'b1;
            shift_pair(1'b0, 1'b0);
            commit_req = 1'b0;
            if (i < CL - 1) chk("rb_busy_mid", 16'(busy), 16'h1);
        end
        chk("rb_done_busy", 16'(busy), 16'h0);
        chk("rb_done_count", 16'(bit_count), 16'h0);
        chk("rb_cfg", cfg_bits, 16'h3CA5);
        chk("rb_valid", 16'(cfg_valid), 16'h1);

        // Reset mid-frame discards everything, shadow included.
        shift_bytes(8'hF0, 8'hF0, 4);
        chk("mid_count", 16'(bit_count), 16'd4);
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
        chk("mrst_cfg", cfg_bits, 16'h0000);
        chk("mrst_valid", 16'(cfg_valid), 16'h0);
        chk("mrst_isol", 16'(isol_n_out), 16'h0);
        chk("mrst_state", 16'(fsm_state), 16'h0);
        chk("mrst_tail", 16'(ccff_tail), 16'h0);
        chk("mrst_count", 16'(bit_count), 16'h0);

        // final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
